// File: rtl/pc_trace_pkg.sv
// Shared types for the PC trace controller: run-state encoding and trace entry layout.
// Build option TRACE_OVERWRITE_EN selects the overflow policy inside trace_fifo.
package pc_trace_pkg;

  localparam int TRACE_ADDR_W = 32;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RUN     = 2'd1,
    S_HALTED  = 2'd2,
    S_TIMEOUT = 2'd3
  } state_t;

  // Entry layout at the default address width; rd_data is this struct packed MSB-first.
  typedef struct packed {
    logic [TRACE_ADDR_W-1:0] pc;
    logic [31:0]             instr;
    logic [TRACE_ADDR_W-1:0] npc;
  } trace_entry_t;

  function automatic int entry_w(input int addr_w);
    return 2 * addr_w + 32;
  endfunction

endpackage

// File: rtl/trace_fifo.sv
// Circular trace buffer with an extra pointer bit for full/empty and a saturating drop counter.
// TRACE_OVERWRITE_EN: overflow evicts the oldest entry; otherwise the incoming entry is dropped.
module trace_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 96
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full,
  output logic [15:0]      drop_cnt
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W:0]   wr_ptr;
  logic [PTR_W:0]   rd_ptr;
  logic             do_pop;
  logic             overflow;
  logic             do_write;
  logic             adv_rd;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                    (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign do_pop   = rd_en && !empty;
  // A pop in the same cycle frees the slot, so a write to a full buffer is only lost without one.
  assign overflow = wr_en && full && !do_pop;

`ifdef TRACE_OVERWRITE_EN
  assign do_write = wr_en;
  assign adv_rd   = do_pop || overflow;
`else
  assign do_write = wr_en && !overflow;
  assign adv_rd   = do_pop;
`endif

  always_ff @(posedge clk) begin
    if (do_write) mem[wr_ptr[PTR_W-1:0]] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      drop_cnt <= '0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + 1'b1;
      if (adv_rd)   rd_ptr <= rd_ptr + 1'b1;
      if (overflow && (drop_cnt != 16'hFFFF)) drop_cnt <= drop_cnt + 16'd1;
    end
  end

  assign rd_data = mem[rd_ptr[PTR_W-1:0]];

endmodule

// File: rtl/pc_trace_ctrl.sv
// Run controller for CPU commit tracing: detects halt (repeated self-loop) and cycle timeout.
// Overflow policy of the trace buffer is selected by TRACE_OVERWRITE_EN.
module pc_trace_ctrl
  import pc_trace_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DEPTH       = 16,
  parameter int MAX_CYCLES  = 200,
  parameter int HALT_REPEAT = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  commit_valid,
  input  logic [ADDR_W-1:0]     pc,
  input  logic [ADDR_W-1:0]     npc,
  input  logic [31:0]           instr,
  input  logic                  rd_en,
  output logic [2*ADDR_W+31:0]  rd_data,
  output logic                  empty,
  output logic                  full,
  output logic [15:0]           drop_cnt,
  output logic [31:0]           cycle_cnt,
  output logic                  halted,
  output logic                  timeout
);

  localparam int ENTRY_W = entry_w(ADDR_W);
  localparam int REP_W   = $clog2(HALT_REPEAT + 1);

  state_t           state;
  logic [REP_W-1:0] repeat_cnt;
  logic             trace_wr;
  logic             self_loop;
  logic             halt_hit;
  logic [31:0]      cycle_next;

  assign trace_wr   = (state == S_RUN) && commit_valid;
  assign self_loop  = (npc == pc);
  assign halt_hit   = trace_wr && self_loop && (repeat_cnt == REP_W'(HALT_REPEAT - 1));
  assign cycle_next = cycle_cnt + 32'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= S_IDLE;
      cycle_cnt  <= '0;
      repeat_cnt <= '0;
      halted     <= 1'b0;
      timeout    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_HALTED, S_TIMEOUT: begin
          if (start) begin
            state      <= S_RUN;
            cycle_cnt  <= '0;
            repeat_cnt <= '0;
            halted     <= 1'b0;
            timeout    <= 1'b0;
          end
        end
        S_RUN: begin
          cycle_cnt <= cycle_next;
          if (trace_wr) repeat_cnt <= self_loop ? repeat_cnt + 1'b1 : '0;
          // Halt wins when both terminations land on the same cycle.
          if (halt_hit) begin
            state  <= S_HALTED;
            halted <= 1'b1;
          end else if (cycle_next == 32'(MAX_CYCLES)) begin
            state   <= S_TIMEOUT;
            timeout <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  trace_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .wr_en    (trace_wr),
    .wr_data  ({pc, instr, npc}),
    .rd_en    (rd_en),
    .rd_data  (rd_data),
    .empty    (empty),
    .full     (full),
    .drop_cnt (drop_cnt)
  );

endmodule

// File: tb/tb_pc_trace_ctrl.sv
// Directed bench for pc_trace_ctrl: a vector table for basic trace/readback plus hand sequences
// for halt, timeout, overflow (both TRACE_OVERWRITE_EN builds) and mid-run reset.
module tb_pc_trace_ctrl;
  import pc_trace_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0;
  logic        commit_valid = 1'b0;
  logic [31:0] pc = '0;
  logic [31:0] npc = '0;
  logic [31:0] instr = '0;
  logic        rd_en = 1'b0;
  logic [95:0] rd_data;
  logic        empty;
  logic        full;
  logic [15:0] drop_cnt;
  logic [31:0] cycle_cnt;
  logic        halted;
  logic        timeout;

  int ncheck = 0;
  int nfail  = 0;

  pc_trace_ctrl #(
    .ADDR_W      (32),
    .DEPTH       (16),
    .MAX_CYCLES  (200),
    .HALT_REPEAT (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .commit_valid (commit_valid),
    .pc           (pc),
    .npc          (npc),
    .instr        (instr),
    .rd_en        (rd_en),
    .rd_data      (rd_data),
    .empty        (empty),
    .full         (full),
    .drop_cnt     (drop_cnt),
    .cycle_cnt    (cycle_cnt),
    .halted       (halted),
    .timeout      (timeout)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        commit;
    logic [31:0] pc;
    logic [31:0] npc;
    logic [31:0] instr;
    logic        rd;
    logic        exp_empty;
    logic [95:0] exp_head;
    logic [31:0] exp_cycle;
  } vec_t;

  vec_t vecs [11];

  function automatic logic [95:0] mk(input logic [31:0] p, input logic [31:0] i, input logic [31:0] n);
    trace_entry_t e;
    e.pc    = p;
    e.instr = i;
    e.npc   = n;
    return e;
  endfunction

  task automatic chk(input string name, input logic [95:0] act, input logic [95:0] exp);
    ncheck++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic do_commit(input logic [31:0] p, input logic [31:0] i, input logic [31:0] n);
    commit_valid = 1'b1;
    pc = p;
    instr = i;
    npc = n;
    tick();
    commit_valid = 1'b0;
  endtask

  task automatic do_pop();
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
  endtask

  initial begin
    int first;
    logic [95:0] exp;

    // Table: 5 commits, then 5 pops, then one idle cycle.
    for (int i = 0; i < 11; i++) begin
      vecs[i].commit    = (i < 5);
      vecs[i].pc        = (i < 5) ? 32'(4 * i) : 32'h0;
      vecs[i].npc       = (i < 5) ? 32'(4 * i + 4) : 32'h0;
      vecs[i].instr     = (i < 5) ? 32'(32'h13 + i) : 32'h0;
      vecs[i].rd        = (i >= 5) && (i < 10);
      vecs[i].exp_empty = (i >= 9);
      vecs[i].exp_head  = (i < 5) ? mk(32'h0, 32'h13, 32'h4)
                                  : mk(32'(4 * (i - 4)), 32'(32'h13 + i - 4), 32'(4 * (i - 4) + 4));
      vecs[i].exp_cycle = 32'(i + 1);
    end

    // Reset state
    do_reset();
    chk("reset_empty", 96'(empty), 96'(1'b1));
    chk("reset_full", 96'(full), 96'(1'b0));
    chk("reset_cycle", 96'(cycle_cnt), 96'(0));
    chk("reset_drop", 96'(drop_cnt), 96'(0));
    chk("reset_halted", 96'(halted), 96'(1'b0));
    chk("reset_timeout", 96'(timeout), 96'(1'b0));

    // Commits before start are ignored
    do_commit(32'h44, 32'h1, 32'h48);
    chk("idle_commit_ignored", 96'(empty), 96'(1'b1));

    // Basic trace and readback in order
    do_start();
    chk("start_cycle", 96'(cycle_cnt), 96'(0));
    for (int i = 0; i < 11; i++) begin
      commit_valid = vecs[i].commit;
      pc    = vecs[i].pc;
      npc   = vecs[i].npc;
      instr = vecs[i].instr;
      rd_en = vecs[i].rd;
      tick();
      commit_valid = 1'b0;
      rd_en = 1'b0;
      $display("vec %0d: commit=%0b pc=%0h rd=%0b -> empty=%0b head_pc=%0h cycle=%0d",
               i, vecs[i].commit, vecs[i].pc, vecs[i].rd, empty, rd_data[95:64], cycle_cnt);
      chk($sformatf("vec%0d_empty", i), 96'(empty), 96'(vecs[i].exp_empty));
      chk($sformatf("vec%0d_cycle", i), 96'(cycle_cnt), 96'(vecs[i].exp_cycle));
      if (!vecs[i].exp_empty) chk($sformatf("vec%0d_head", i), rd_data, vecs[i].exp_head);
    end

    // Halt after three self-loop commits
    do_reset();
    do_start();
    for (int k = 0; k < 3; k++) begin
      do_commit(32'h3C, 32'h6F, 32'h3C);
      $display("halt seq commit %0d: halted=%0b cycle=%0d", k, halted, cycle_cnt);
      chk($sformatf("halt_flag_%0d", k), 96'(halted), 96'(k == 2));
    end
    chk("halt_cycle", 96'(cycle_cnt), 96'(3));
    chk("halt_no_timeout", 96'(timeout), 96'(1'b0));
    for (int k = 0; k < 4; k++) do_commit(32'h40, 32'h13, 32'h44);
    chk("halt_cycle_frozen", 96'(cycle_cnt), 96'(3));
    chk("halt_still", 96'(halted), 96'(1'b1));
    for (int k = 0; k < 3; k++) begin
      chk($sformatf("halt_entry_empty_%0d", k), 96'(empty), 96'(1'b0));
      chk($sformatf("halt_entry_%0d", k), rd_data, mk(32'h3C, 32'h6F, 32'h3C));
      do_pop();
    end
    chk("halt_drained", 96'(empty), 96'(1'b1));

    // Timeout; interrupted self-loop run must not halt
    do_reset();
    do_start();
    do_commit(32'h80, 32'h6F, 32'h80);
    do_commit(32'h80, 32'h6F, 32'h80);
    do_commit(32'h80, 32'h13, 32'h84);
    do_commit(32'h84, 32'h6F, 32'h84);
    do_commit(32'h84, 32'h6F, 32'h84);
    chk("to_no_halt", 96'(halted), 96'(1'b0));
    chk("to_cycle5", 96'(cycle_cnt), 96'(5));
    for (int k = 0; k < 194; k++) tick();
    chk("to_cycle199", 96'(cycle_cnt), 96'(199));
    chk("to_not_yet", 96'(timeout), 96'(1'b0));
    tick();
    $display("timeout seq: cycle=%0d timeout=%0b halted=%0b", cycle_cnt, timeout, halted);
    chk("to_cycle200", 96'(cycle_cnt), 96'(200));
    chk("to_flag", 96'(timeout), 96'(1'b1));
    chk("to_halted0", 96'(halted), 96'(1'b0));
    tick();
    chk("to_cycle_frozen", 96'(cycle_cnt), 96'(200));

    // Overflow: 20 commits into 16 entries
    do_reset();
    do_start();
    for (int k = 0; k < 20; k++) do_commit(32'(4 * k), 32'(32'h100 + k), 32'(4 * k + 4));
`ifdef TRACE_OVERWRITE_EN
    first = 4;
`else
    first = 0;
`endif
    chk("ovf_drop", 96'(drop_cnt), 96'(4));
    chk("ovf_full", 96'(full), 96'(1'b1));
    chk("ovf_head", rd_data, mk(32'(4 * first), 32'(32'h100 + first), 32'(4 * first + 4)));

    // Full buffer: pop and commit together, nothing dropped
    commit_valid = 1'b1;
    pc = 32'h200;
    instr = 32'h1FF;
    npc = 32'h204;
    rd_en = 1'b1;
    tick();
    commit_valid = 1'b0;
    rd_en = 1'b0;
    $display("pop+commit on full: drop=%0d full=%0b head_pc=%0h", drop_cnt, full, rd_data[95:64]);
    chk("popw_drop", 96'(drop_cnt), 96'(4));
    chk("popw_full", 96'(full), 96'(1'b1));
    for (int k = 0; k < 16; k++) begin
      if (k < 15) exp = mk(32'(4 * (first + 1 + k)), 32'(32'h100 + first + 1 + k), 32'(4 * (first + 1 + k) + 4));
      else        exp = mk(32'h200, 32'h1FF, 32'h204);
      chk($sformatf("drain_%0d", k), rd_data, exp);
      do_pop();
    end
    chk("drain_empty", 96'(empty), 96'(1'b1));
    do_pop();
    chk("pop_on_empty", 96'(empty), 96'(1'b1));
    chk("pop_on_empty_full", 96'(full), 96'(1'b0));

    // Reset mid-run after 7 commits
    do_reset();
    do_start();
    for (int k = 0; k < 7; k++) do_commit(32'(32'h300 + 4 * k), 32'h13, 32'(32'h304 + 4 * k));
    chk("pre_rst_cycle", 96'(cycle_cnt), 96'(7));
    rst = 1'b1;
    #2;
    $display("async reset mid-run: empty=%0b cycle=%0d", empty, cycle_cnt);
    chk("arst_empty", 96'(empty), 96'(1'b1));
    chk("arst_cycle", 96'(cycle_cnt), 96'(0));
    chk("arst_full", 96'(full), 96'(1'b0));
    tick();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) do_commit(32'h400, 32'h13, 32'h404);
    chk("post_rst_ignored", 96'(empty), 96'(1'b1));
    chk("post_rst_cycle", 96'(cycle_cnt), 96'(0));
    do_start();
    do_commit(32'h500, 32'hABC, 32'h504);
    chk("restart_empty", 96'(empty), 96'(1'b0));
    chk("restart_head", rd_data, mk(32'h500, 32'hABC, 32'h504));
    chk("restart_cycle", 96'(cycle_cnt), 96'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", ncheck, nfail);
    $finish;
  end

endmodule
